// File: rtl/chacha20_decrypt.sv
// ChaCha20 receive-side stream decryptor with a double-buffered keystream.
// Ciphertext words are XORed with keystream words; plaintext is registered.

module chacha20_block #(
  parameter int PAR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             block_start,
  input  logic [255:0]     key,
  input  logic [31:0]      counter,
  input  logic [95:0]      nonce,
  input  logic [PAR_W-1:0] parallel_blocks,
  output logic [511:0]     keystream_blocks,
  output logic             done
);

  logic [511:0] r_x;
  logic [511:0] r_s;
  logic [511:0] r_ks;
  logic [3:0]   r_cnt;
  logic         r_run;
  logic         r_done;
  logic [511:0] w_init;
  logic [511:0] w_dr;
  logic [511:0] w_sum;
  logic         w_unused_par;

  // Only a single block per request is produced here.
  assign w_unused_par = ^parallel_blocks;

  function automatic logic [127:0] qr(
    input logic [31:0] ai,
    input logic [31:0] bi,
    input logic [31:0] ci,
    input logic [31:0] di
  );
    logic [31:0] a, b, c, d;
    a = ai; b = bi; c = ci; d = di;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] dround(input logic [511:0] x);
    logic [31:0]  w [16];
    logic [511:0] y;
    for (int i = 0; i < 16; i++) w[i] = x[32*i +: 32];
    {w[0], w[4], w[8],  w[12]} = qr(w[0], w[4], w[8],  w[12]);
    {w[1], w[5], w[9],  w[13]} = qr(w[1], w[5], w[9],  w[13]);
    {w[2], w[6], w[10], w[14]} = qr(w[2], w[6], w[10], w[14]);
    {w[3], w[7], w[11], w[15]} = qr(w[3], w[7], w[11], w[15]);
    {w[0], w[5], w[10], w[15]} = qr(w[0], w[5], w[10], w[15]);
    {w[1], w[6], w[11], w[12]} = qr(w[1], w[6], w[11], w[12]);
    {w[2], w[7], w[8],  w[13]} = qr(w[2], w[7], w[8],  w[13]);
    {w[3], w[4], w[9],  w[14]} = qr(w[3], w[4], w[9],  w[14]);
    for (int i = 0; i < 16; i++) y[32*i +: 32] = w[i];
    return y;
  endfunction

  assign w_init = {nonce, counter, key,
                   128'h6b206574_79622d32_3320646e_61707865};
  assign w_dr   = dround(r_x);

  // Feed-forward add of the original state, word by word.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 16; i++)
      w_sum[32*i +: 32] = w_dr[32*i +: 32] + r_s[32*i +: 32];
  end

  // One double round per cycle; ten cycles per block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_s    <= '0;
      r_ks   <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (block_start) begin
        r_x   <= w_init;
        r_s   <= w_init;
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_x   <= w_dr;
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd9) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
          r_ks   <= w_sum;
        end
      end
    end
  end

  assign keystream_blocks = r_ks;
  assign done             = r_done;

endmodule

module chacha20_decrypt #(
  parameter int         KS_SLOTS = 2,
  parameter logic [1:0] BLK_PAR  = 2'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ct_data,
  input  logic [3:0]   ct_keep,
  input  logic         ct_valid,
  input  logic         ct_last,
  output logic         ct_ready,
  output logic [31:0]  pt_data,
  output logic [3:0]   pt_keep,
  output logic         pt_valid,
  output logic         pt_last,
  input  logic         pt_ready,
  output logic         busy,
  output logic         done,
  output logic         ctr_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [255:0]        r_key;
  logic [95:0]         r_nonce;
  logic [31:0]         r_req_ctr;
  logic                r_bs;
  logic                r_pend;
  logic                r_req_slot;
  logic                r_fill;
  logic                r_cur;
  logic [3:0]          r_widx;
  logic                r_seen_last;
  logic                r_ovf;
  logic                r_out_done;
  logic [KS_SLOTS-1:0] r_slot_vld;
  logic [511:0]        r_slot [KS_SLOTS];
  logic [31:0]         r_pt_data;
  logic [3:0]          r_pt_keep;
  logic                r_pt_valid;
  logic                r_pt_last;
  logic                r_done;

  logic                w_rst_n;
  logic [511:0]        w_blk_ks;
  logic                w_blk_done;
  logic                w_ct_ready;
  logic                w_start_acc;
  logic                w_pref;
  logic                w_finish;
  logic                w_hs;
  logic                w_last_out;
  logic [31:0]         w_ks_word;
  logic [31:0]         w_mask;

  assign w_rst_n = ~rst;

  chacha20_block #(
    .PAR_W(2)
  ) u_blk (
    .clk              (clk),
    .rst_n            (w_rst_n),
    .block_start      (r_bs),
    .key              (r_key),
    .counter          (r_req_ctr),
    .nonce            (r_nonce),
    .parallel_blocks  (BLK_PAR),
    .keystream_blocks (w_blk_ks),
    .done             (w_blk_done)
  );

  assign w_hs       = ct_valid && w_ct_ready;
  assign w_last_out = r_pt_valid && pt_ready && r_pt_last;
  assign w_ks_word  = r_slot[r_cur][r_widx*32 +: 32];
  assign w_mask     = {{8{ct_keep[3]}}, {8{ct_keep[2]}},
                       {8{ct_keep[1]}}, {8{ct_keep[0]}}};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, accept rule, prefetch and frame-end decode.
  always_comb begin
    w_next      = r_state;
    w_ct_ready  = 1'b0;
    w_start_acc = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = S_FILL;
        end
      end
      S_FILL: begin
        if (w_blk_done) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_ct_ready = r_slot_vld[r_cur] &&
                     (!r_pt_valid || pt_ready);
        if (ct_valid && w_ct_ready && ct_last)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_pend && (r_out_done || w_last_out)) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // A frame stuck on counter wrap can only be left by a new start.
    if (r_state != S_IDLE && r_ovf && start) begin
      w_start_acc = 1'b1;
      w_ct_ready  = 1'b0;
      w_next      = S_FILL;
    end
    w_pref = (r_state == S_FILL || r_state == S_STREAM) &&
             !r_pend && !r_seen_last && !r_ovf &&
             !r_slot_vld[r_fill];
  end

  // Generator requests, slot bookkeeping and frame context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key       <= '0;
      r_nonce     <= '0;
      r_req_ctr   <= '0;
      r_bs        <= 1'b0;
      r_pend      <= 1'b0;
      r_req_slot  <= 1'b0;
      r_fill      <= 1'b0;
      r_cur       <= 1'b0;
      r_widx      <= '0;
      r_seen_last <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_done  <= 1'b0;
      r_slot_vld  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_bs   <= 1'b0;
      r_done <= w_finish;
      if (w_blk_done) begin
        r_slot_vld[r_req_slot] <= 1'b1;
        r_pend                 <= 1'b0;
      end
      if (w_hs) begin
        r_widx <= r_widx + 4'd1;
        if (r_widx == 4'd15) begin
          r_slot_vld[r_cur] <= 1'b0;
          r_cur             <= ~r_cur;
        end
        if (ct_last) r_seen_last <= 1'b1;
      end
      if (w_pref) begin
        if (r_req_ctr == 32'hFFFF_FFFF) begin
          r_ovf <= 1'b1;
        end else begin
          r_req_ctr  <= r_req_ctr + 32'd1;
          r_bs       <= 1'b1;
          r_pend     <= 1'b1;
          r_req_slot <= r_fill;
          r_fill     <= ~r_fill;
        end
      end
      if (r_state == S_DRAIN && w_last_out)
        r_out_done <= 1'b1;
      if (w_start_acc) begin
        r_key       <= key;
        r_nonce     <= nonce;
        r_req_ctr   <= counter;
        r_bs        <= 1'b1;
        r_pend      <= 1'b1;
        r_req_slot  <= 1'b0;
        r_fill      <= 1'b1;
        r_cur       <= 1'b0;
        r_widx      <= '0;
        r_seen_last <= 1'b0;
        r_ovf       <= 1'b0;
        r_out_done  <= 1'b0;
        r_slot_vld  <= '0;
      end
      if (w_finish) r_slot_vld <= '0;
    end
  end

  // Keystream slot storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KS_SLOTS; i++) r_slot[i] <= '0;
    end else if (w_blk_done) begin
      r_slot[r_req_slot] <= w_blk_ks;
    end
  end

  // Plaintext output register; holds until the sink takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pt_data  <= '0;
      r_pt_keep  <= '0;
      r_pt_valid <= 1'b0;
      r_pt_last  <= 1'b0;
    end else if (w_hs) begin
      r_pt_data  <= (ct_data ^ w_ks_word) & w_mask;
      r_pt_keep  <= ct_keep;
      r_pt_last  <= ct_last;
      r_pt_valid <= 1'b1;
    end else if (pt_ready) begin
      r_pt_valid <= 1'b0;
    end
  end

  assign ct_ready     = w_ct_ready;
  assign pt_data      = r_pt_data;
  assign pt_keep      = r_pt_keep;
  assign pt_valid     = r_pt_valid;
  assign pt_last      = r_pt_last;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign ctr_overflow = r_ovf;

endmodule

// File: tb/tb_chacha20_decrypt.sv
// Directed bench for chacha20_decrypt: RFC 8439 vector, backpressure,
// block boundaries, counter wrap, mid-frame reset and a 64-word frame.

module tb_chacha20_decrypt;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [31:0]  counter = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  ct_data = '0;
  logic [3:0]   ct_keep = '0;
  logic         ct_valid = 1'b0;
  logic         ct_last = 1'b0;
  logic         ct_ready;
  logic [31:0]  pt_data;
  logic [3:0]   pt_keep;
  logic         pt_valid;
  logic         pt_last;
  logic         pt_ready = 1'b1;
  logic         busy;
  logic         done;
  logic         ctr_overflow;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] g_pt  [64];
  logic [31:0] g_ct  [64];
  logic [31:0] g_got [64];
  logic [3:0]  g_lkeep;
  int          g_n;
  int          g_idx;

  localparam int QI [8][4] = '{
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  always #5 clk = ~clk;

  chacha20_decrypt dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key          (key),
    .counter      (counter),
    .nonce        (nonce),
    .ct_data      (ct_data),
    .ct_keep      (ct_keep),
    .ct_valid     (ct_valid),
    .ct_last      (ct_last),
    .ct_ready     (ct_ready),
    .pt_data      (pt_data),
    .pt_keep      (pt_keep),
    .pt_valid     (pt_valid),
    .pt_last      (pt_last),
    .pt_ready     (pt_ready),
    .busy         (busy),
    .done         (done),
    .ctr_overflow (ctr_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k,
                                             input logic [31:0] c,
                                             input logic [95:0] n);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    int a, b, cc, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    for (int i = 0; i < 16; i++) x[i] = s[i];
    for (int rr = 0; rr < 10; rr++) begin
      for (int q = 0; q < 8; q++) begin
        a = QI[q][0]; b = QI[q][1]; cc = QI[q][2]; d = QI[q][3];
        x[a] += x[b];  x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] += x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] += x[b];  x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] += x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [3:0] keep_of(input int i);
    return (i == g_n - 1) ? g_lkeep : 4'hF;
  endfunction

  task automatic build();
    logic [511:0] blk;
    for (int i = 0; i < g_n; i++) begin
      blk = ref_block(key, counter + 32'(i / 16), nonce);
      g_ct[i] = g_pt[i] ^ blk[32*(i % 16) +: 32];
    end
  endtask

  task automatic run_frame(input int stall_at, input int abort_at,
                           output int nout, output int ndone);
    int idx, oidx, stall_cnt, idle, done_cyc;
    logic [31:0] held;
    logic hs_ct, hs_pt;
    idx = 0; oidx = 0; stall_cnt = 0; idle = 0;
    ndone = 0; done_cyc = 0; held = '0;
    @(negedge clk);
    ct_valid = 1'b0; ct_last = 1'b0; pt_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ovf_after_start", ctr_overflow, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_pt_valid", pt_valid, 0);
        check("abort_pt_data", pt_data, 0);
        check("abort_ct_ready", ct_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        break;
      end
      pt_ready = !(stall_at >= 0 && oidx == stall_at &&
                   pt_valid && stall_cnt < 5);
      ct_valid = (idx < g_n);
      ct_data  = (idx < g_n) ? g_ct[idx] : 32'h0;
      ct_keep  = keep_of(idx);
      ct_last  = (idx == g_n - 1);
      #1;
      hs_ct = ct_valid && ct_ready;
      hs_pt = pt_valid && pt_ready;
      if (!pt_ready) begin
        check("stall_ct_ready", ct_ready, 0);
        if (stall_cnt > 0) check("stall_pt_data", pt_data, held);
        held = pt_data;
        stall_cnt++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (hs_pt) begin
        if (oidx < g_n) begin
          g_got[oidx] = pt_data;
          check($sformatf("pt_data[%0d]", oidx), pt_data,
                g_pt[oidx] & kmask(keep_of(oidx)));
          check($sformatf("pt_keep[%0d]", oidx), pt_keep, keep_of(oidx));
          check($sformatf("pt_last[%0d]", oidx), pt_last,
                oidx == g_n - 1);
        end else begin
          check("extra_pt_word", oidx, g_n - 1);
        end
        oidx++;
      end
      idle = (hs_ct || hs_pt) ? 0 : idle + 1;
      if (ndone > 0 && cyc - done_cyc > 4) break;
      if (idle > 60) break;
      @(posedge clk);
      if (hs_ct) idx++;
      @(negedge clk);
    end
    nout  = oidx;
    g_idx = idx;
  endtask

  initial begin
    string txt;
    int nout, nd;
    txt = {"Ladies and Gentlemen of the class of '99: If I could ",
           "offer you only one tip for the future, sunscreen would be it."};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ct_ready", ct_ready, 0);
    check("rst_pt_valid", pt_valid, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ctr_overflow, 0);
    rst = 1'b0;

    // RFC 8439 2.4.2 with a 5-cycle sink stall at word 10.
    for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
    nonce = '0;
    nonce[63:56] = 8'h4a;
    counter = 32'd1;
    g_n = 29;
    g_lkeep = 4'b0011;
    for (int w = 0; w < 29; w++)
      for (int b = 0; b < 4; b++)
        g_pt[w][8*b +: 8] = (4*w + b < txt.len()) ? txt[4*w + b] : 8'hA5;
    build();
    g_ct[0] = 32'h9a352e6e;
    run_frame(10, -1, nout, nd);
    check("rfc_words", nout, 29);
    check("rfc_done", nd, 1);
    check("rfc_word0", g_got[0], 32'h6964614c);
    check("rfc_word28", g_got[28], 32'h00002e74);
    check("rfc_busy_end", busy, 0);

    // Three blocks, continuous flow, counter 7.
    for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
    nonce = {$urandom, $urandom, $urandom};
    counter = 32'd7;
    g_n = 40;
    g_lkeep = 4'hF;
    for (int i = 0; i < 40; i++) g_pt[i] = $urandom;
    build();
    run_frame(-1, -1, nout, nd);
    check("blk_words", nout, 40);
    check("blk_done", nd, 1);

    // Counter wrap: only the first block is usable.
    counter = 32'hFFFF_FFFF;
    g_n = 20;
    for (int i = 0; i < 20; i++) g_pt[i] = $urandom;
    build();
    run_frame(-1, -1, nout, nd);
    check("ovf_words", nout, 16);
    check("ovf_done", nd, 0);
    check("ovf_flag", ctr_overflow, 1);
    check("ovf_ct_ready", ct_ready, 0);
    check("ovf_ct_idx", g_idx, 16);

    // New start clears the flag and decrypts a short frame.
    counter = 32'd5;
    g_n = 8;
    g_lkeep = 4'b0111;
    for (int i = 0; i < 8; i++) g_pt[i] = $urandom;
    build();
    run_frame(-1, -1, nout, nd);
    check("post_ovf_words", nout, 8);
    check("post_ovf_done", nd, 1);
    check("post_ovf_flag", ctr_overflow, 0);

    // Reset at word 7, then the same frame again.
    counter = 32'd3;
    g_n = 24;
    g_lkeep = 4'hF;
    for (int i = 0; i < 24; i++) g_pt[i] = $urandom;
    build();
    run_frame(-1, 7, nout, nd);
    ct_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame(-1, -1, nout, nd);
    check("rst_rerun_words", nout, 24);
    check("rst_rerun_done", nd, 1);

    // 64 random words encrypted by the reference model.
    for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
    nonce = {$urandom, $urandom, $urandom};
    counter = $urandom & 32'h0FFF_FFFF;
    g_n = 64;
    for (int i = 0; i < 64; i++) g_pt[i] = $urandom;
    build();
    run_frame(-1, -1, nout, nd);
    check("rt_words", nout, 64);
    check("rt_done", nd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
